// File: rtl/dwt_pair_feeder.sv
// Row-wise pixel fetcher for the 5/3 lifting stage: reads image memory and emits
// (x[2n], x[2n+1], x[2n+2]) triples over valid/ready, mirroring x[IMG_W-2] at the right edge.
module dwt_pair_feeder #(
    parameter int IMG_W = 64,
    parameter int IMG_H = 64,
    parameter int AW    = 12
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic          mem_rd_en,
    output logic [AW-1:0] mem_addr,
    input  logic [7:0]    mem_rdata,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [7:0]    out_even,
    output logic [7:0]    out_odd,
    output logic [7:0]    out_next,
    output logic          out_row_first,
    output logic          out_row_last,
    output logic          out_frame_last
);

    localparam int NP = IMG_W / 2;
    localparam int NW = (NP > 1) ? $clog2(NP) : 1;
    localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;

    typedef enum logic [2:0] {IDLE, RD_E, RD_O, RD_N, CAP, OUT} state_e;

    state_e         state_q;
    logic           from_e_q;
    logic [NW-1:0]  n_q;
    logic [RW-1:0]  row_q;
    logic [AW-1:0]  base_q;
    logic [7:0]     even_q, odd_q, next_q;
    logic           valid_q, done_q, rf_q, rl_q, fl_q;

    logic           last_pair, last_row;
    logic [AW-1:0]  col;

    assign last_pair = (n_q == NW'(NP - 1));
    assign last_row  = (row_q == RW'(IMG_H - 1));
    assign col       = AW'({n_q, 1'b0});

    // Address is 0 whenever no read is issued, so reset and idle both show 0.
    always_comb begin
        mem_rd_en = 1'b0;
        mem_addr  = '0;
        case (state_q)
            RD_E: begin
                mem_rd_en = 1'b1;
                mem_addr  = base_q + col;
            end
            RD_O: begin
                mem_rd_en = 1'b1;
                mem_addr  = base_q + col + AW'(1);
            end
            RD_N: begin
                mem_rd_en = 1'b1;
                mem_addr  = last_pair ? base_q + AW'(IMG_W - 2) : base_q + col + AW'(2);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            from_e_q <= 1'b0;
            n_q      <= '0;
            row_q    <= '0;
            base_q   <= '0;
            even_q   <= '0;
            odd_q    <= '0;
            next_q   <= '0;
            valid_q  <= 1'b0;
            done_q   <= 1'b0;
            rf_q     <= 1'b0;
            rl_q     <= 1'b0;
            fl_q     <= 1'b0;
        end else begin
            done_q   <= 1'b0;
            from_e_q <= (state_q == RD_E);
            case (state_q)
                IDLE: if (start) begin
                    n_q     <= '0;
                    row_q   <= '0;
                    base_q  <= '0;
                    state_q <= RD_E;
                end
                RD_E: state_q <= RD_O;
                RD_O: begin
                    // Only the first pair of a row reads its even sample; later pairs reuse next.
                    if (from_e_q) even_q <= mem_rdata;
                    state_q <= RD_N;
                end
                RD_N: begin
                    odd_q   <= mem_rdata;
                    state_q <= CAP;
                end
                CAP: begin
                    next_q  <= mem_rdata;
                    valid_q <= 1'b1;
                    rf_q    <= (n_q == '0);
                    rl_q    <= last_pair;
                    fl_q    <= last_pair && last_row;
                    state_q <= OUT;
                end
                OUT: if (out_ready) begin
                    valid_q <= 1'b0;
                    if (!last_pair) begin
                        even_q  <= next_q;
                        n_q     <= n_q + 1'b1;
                        state_q <= RD_O;
                    end else if (!last_row) begin
                        base_q  <= base_q + AW'(IMG_W);
                        row_q   <= row_q + 1'b1;
                        n_q     <= '0;
                        state_q <= RD_E;
                    end else begin
                        done_q  <= 1'b1;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy           = (state_q != IDLE);
    assign done           = done_q;
    assign out_valid      = valid_q;
    assign out_even       = even_q;
    assign out_odd        = odd_q;
    assign out_next       = next_q;
    assign out_row_first  = rf_q;
    assign out_row_last   = rl_q;
    assign out_frame_last = fl_q;

endmodule

// File: tb/tb_dwt_pair_feeder.sv
// Bench for dwt_pair_feeder: two 8-wide instances (1 row and 2 rows) checked against
// a triple/address list computed directly from memory contents.
module tb_dwt_pair_feeder;

    logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, out_ready = 1'b1, sel = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [7:0] mem [16];

    logic start_a, start_b;
    assign start_a = start & ~sel;
    assign start_b = start & sel;

    logic       busy_a, done_a, rd_a, val_a, rf_a, rl_a, fl_a;
    logic [2:0] addr_a;
    logic [7:0] rdata_a, e_a, o_a, n_a;
    logic       busy_b, done_b, rd_b, val_b, rf_b, rl_b, fl_b;
    logic [3:0] addr_b;
    logic [7:0] rdata_b, e_b, o_b, n_b;

    dwt_pair_feeder #(.IMG_W(8), .IMG_H(1), .AW(3)) u_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .busy(busy_a), .done(done_a),
        .mem_rd_en(rd_a), .mem_addr(addr_a), .mem_rdata(rdata_a),
        .out_valid(val_a), .out_ready(out_ready), .out_even(e_a), .out_odd(o_a), .out_next(n_a),
        .out_row_first(rf_a), .out_row_last(rl_a), .out_frame_last(fl_a));

    dwt_pair_feeder #(.IMG_W(8), .IMG_H(2), .AW(4)) u_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .busy(busy_b), .done(done_b),
        .mem_rd_en(rd_b), .mem_addr(addr_b), .mem_rdata(rdata_b),
        .out_valid(val_b), .out_ready(out_ready), .out_even(e_b), .out_odd(o_b), .out_next(n_b),
        .out_row_first(rf_b), .out_row_last(rl_b), .out_frame_last(fl_b));

    always @(posedge clk) if (rd_a) rdata_a <= mem[addr_a];
    always @(posedge clk) if (rd_b) rdata_b <= mem[addr_b];

    // View of the currently selected instance; triple word = {even, odd, next, rf, rl, fl}
    logic        busy, done, rd, val;
    int          addr;
    logic [26:0] tri_w;
    always_comb begin
        busy  = sel ? busy_b : busy_a;
        done  = sel ? done_b : done_a;
        rd    = sel ? rd_b : rd_a;
        val   = sel ? val_b : val_a;
        addr  = sel ? int'(addr_b) : int'(addr_a);
        tri_w = sel ? {e_b, o_b, n_b, rf_b, rl_b, fl_b} : {e_a, o_a, n_a, rf_a, rl_a, fl_a};
    end

    int checks = 0, failures = 0;
    logic [26:0] obs_t[$], exp_t[$];
    int obs_a[$], exp_a[$], hs_cyc[$], rise_cyc[$];
    int start_cyc, done_cyc, stall_cyc, stall_bad;
    logic done_busy;
    bit timed_out;

    // Expected output: for each row r and pair n the triple straight from memory,
    // with the right-edge sample mirrored to column 6; reads are columns 0..7 then 6.
    task automatic build_model(input int h);
        exp_t.delete();
        exp_a.delete();
        for (int r = 0; r < h; r++) begin
            for (int n = 0; n < 4; n++) begin
                logic [7:0] nx;
                nx = (n == 3) ? mem[r*8 + 6] : mem[r*8 + 2*n + 2];
                exp_t.push_back({mem[r*8 + 2*n], mem[r*8 + 2*n + 1], nx,
                                 (n == 0), (n == 3), (n == 3 && r == h - 1)});
            end
            for (int c = 0; c < 8; c++) exp_a.push_back(r*8 + c);
            exp_a.push_back(r*8 + 6);
        end
    endtask

    task automatic fill_mem(input bit ramp);
        for (int i = 0; i < 16; i++) mem[i] = ramp ? 8'(10 * i) : 8'($urandom_range(0, 255));
    endtask

    // bp: 0 always ready, 1 random ready, 2 hold ready low 7 cycles while pair 1 is valid
    task automatic run_frame(input int bp, input bit skip_start, input bit busy_pulse, input bit chain);
        logic [26:0] prev_t;
        bit prev_stall;
        int hold_n;
        obs_t.delete(); obs_a.delete(); hs_cyc.delete(); rise_cyc.delete();
        done_cyc = -1; timed_out = 0; stall_cyc = 0; stall_bad = 0;
        prev_t = '0; prev_stall = 0; hold_n = 0; out_ready = 1'b1;
        @(posedge clk); #1;
        if (skip_start) start = 1'b0;
        else begin
            start = 1'b1;
            start_cyc = cyc;
        end
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            if (rd) obs_a.push_back(addr);
            if (val && rise_cyc.size() == hs_cyc.size()) rise_cyc.push_back(cyc);
            if (prev_stall) begin
                stall_cyc++;
                if (tri_w !== prev_t || rd || !busy) stall_bad++;
            end
            prev_stall = val && !out_ready;
            prev_t = tri_w;
            if (val && out_ready) begin
                obs_t.push_back(tri_w);
                hs_cyc.push_back(cyc);
            end
            if (done) begin
                done_cyc = cyc;
                done_busy = busy;
                if (chain) begin
                    start = 1'b1;
                    start_cyc = cyc;
                end
                break;
            end
            @(posedge clk); #1;
            start = busy_pulse && (cyc == start_cyc + 8);
            case (bp)
                1: out_ready = 1'($urandom_range(0, 1));
                2: begin
                    out_ready = 1'b1;
                    if (val && hs_cyc.size() == 1 && hold_n < 7) begin
                        out_ready = 1'b0;
                        hold_n++;
                    end
                end
                default: out_ready = 1'b1;
            endcase
        end
        if (done_cyc < 0) timed_out = 1;
        out_ready = 1'b1;
    endtask

    task automatic test_reset;
        #12;
        checks++; if ({busy_a, done_a, rd_a, val_a, rf_a, rl_a, fl_a} !== 7'd0) begin
            failures++; $display("FAIL reset_ctrl_a got=%b exp=0", {busy_a, done_a, rd_a, val_a, rf_a, rl_a, fl_a}); end
        checks++; if ({e_a, o_a, n_a, addr_a} !== 27'd0) begin
            failures++; $display("FAIL reset_data_a got=%h exp=0", {e_a, o_a, n_a, addr_a}); end
        checks++; if ({busy_b, done_b, rd_b, val_b, rf_b, rl_b, fl_b} !== 7'd0) begin
            failures++; $display("FAIL reset_ctrl_b got=%b exp=0", {busy_b, done_b, rd_b, val_b, rf_b, rl_b, fl_b}); end
        checks++; if ({e_b, o_b, n_b, addr_b} !== 28'd0) begin
            failures++; $display("FAIL reset_data_b got=%h exp=0", {e_b, o_b, n_b, addr_b}); end
        @(negedge clk); rst_n = 1'b1;
        repeat (2) @(posedge clk);
    endtask

    task automatic test_basic;
        sel = 0; fill_mem(1); build_model(1);
        run_frame(0, 0, 0, 0);
        checks++; if (timed_out) begin failures++; $display("FAIL basic_timeout got=no_done exp=done"); end
        for (int i = 0; i < exp_t.size(); i++) begin
            checks++; if (i >= obs_t.size() || obs_t[i] !== exp_t[i]) begin
                failures++; $display("FAIL basic_triple[%0d] got=%h exp=%h", i, obs_t[i], exp_t[i]); end
        end
        checks++; if (obs_a.size() != 9) begin failures++; $display("FAIL basic_nreads got=%0d exp=9", obs_a.size()); end
        for (int i = 0; i < exp_a.size(); i++) begin
            checks++; if (i >= obs_a.size() || obs_a[i] != exp_a[i]) begin
                failures++; $display("FAIL basic_addr[%0d] got=%0d exp=%0d", i, obs_a[i], exp_a[i]); end
        end
        checks++; if (rise_cyc.size() == 0 || rise_cyc[0] != start_cyc + 5) begin
            failures++; $display("FAIL basic_latency got=%0d exp=%0d", rise_cyc[0], start_cyc + 5); end
        for (int i = 0; i + 1 < rise_cyc.size(); i++) begin
            checks++; if (rise_cyc[i+1] != hs_cyc[i] + 4) begin
                failures++; $display("FAIL basic_gap[%0d] got=%0d exp=%0d", i, rise_cyc[i+1], hs_cyc[i] + 4); end
        end
        checks++; if (hs_cyc.size() == 0 || done_cyc != hs_cyc[hs_cyc.size()-1] + 1 || done_busy !== 1'b0) begin
            failures++; $display("FAIL basic_done got=%0d/%b exp=last_hs+1/0", done_cyc, done_busy); end
    endtask

    task automatic test_backpressure;
        sel = 0; fill_mem(1); build_model(1);
        run_frame(2, 0, 0, 0);
        checks++; if (stall_cyc != 7 || stall_bad != 0) begin
            failures++; $display("FAIL bp_stall got=%0d/%0d exp=7/0", stall_cyc, stall_bad); end
        checks++; if (obs_a.size() != 9) begin failures++; $display("FAIL bp_nreads got=%0d exp=9", obs_a.size()); end
        for (int i = 0; i < exp_t.size(); i++) begin
            checks++; if (i >= obs_t.size() || obs_t[i] !== exp_t[i]) begin
                failures++; $display("FAIL bp_triple[%0d] got=%h exp=%h", i, obs_t[i], exp_t[i]); end
        end
    endtask

    task automatic test_two_rows;
        sel = 1; fill_mem(0); build_model(2);
        run_frame(0, 0, 0, 0);
        checks++; if (timed_out) begin failures++; $display("FAIL rows_timeout got=no_done exp=done"); end
        for (int i = 0; i < exp_t.size(); i++) begin
            checks++; if (i >= obs_t.size() || obs_t[i] !== exp_t[i]) begin
                failures++; $display("FAIL rows_triple[%0d] got=%h exp=%h", i, obs_t[i], exp_t[i]); end
        end
        for (int i = 0; i < exp_a.size(); i++) begin
            checks++; if (i >= obs_a.size() || obs_a[i] != exp_a[i]) begin
                failures++; $display("FAIL rows_addr[%0d] got=%0d exp=%0d", i, obs_a[i], exp_a[i]); end
        end
        // Row boundary costs one extra idle cycle for re-reading the even sample.
        for (int i = 0; i + 1 < rise_cyc.size(); i++) begin
            int g;
            g = exp_t[i][1] ? 5 : 4;
            checks++; if (rise_cyc[i+1] != hs_cyc[i] + g) begin
                failures++; $display("FAIL rows_gap[%0d] got=%0d exp=%0d", i, rise_cyc[i+1], hs_cyc[i] + g); end
        end
    endtask

    task automatic test_random_ready;
        sel = 1; fill_mem(0); build_model(2);
        run_frame(1, 0, 0, 0);
        checks++; if (timed_out) begin failures++; $display("FAIL rand_timeout got=no_done exp=done"); end
        checks++; if (obs_a.size() != 18) begin failures++; $display("FAIL rand_nreads got=%0d exp=18", obs_a.size()); end
        for (int i = 0; i < exp_t.size(); i++) begin
            checks++; if (i >= obs_t.size() || obs_t[i] !== exp_t[i]) begin
                failures++; $display("FAIL rand_triple[%0d] got=%h exp=%h", i, obs_t[i], exp_t[i]); end
        end
    endtask

    task automatic test_reset_abort;
        int bad;
        bit hit;
        sel = 0; fill_mem(1); build_model(1);
        hit = 0; bad = 0;
        @(posedge clk); #1; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        for (int k = 0; k < 50 && !hit; k++) begin
            @(negedge clk);
            if (rd && addr == 6) hit = 1;
        end
        checks++; if (!hit) begin failures++; $display("FAIL abort_reach got=no_rdn exp=rd_addr6"); end
        rst_n = 1'b0; #1;
        checks++; if ({busy, done, rd, val, tri_w} !== 31'd0 || addr != 0) begin
            failures++; $display("FAIL abort_outputs got=%h/%0d exp=0", {busy, done, rd, val, tri_w}, addr); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (done || rd || busy || val) bad++;
        end
        checks++; if (bad != 0) begin failures++; $display("FAIL abort_quiet got=%0d exp=0", bad); end
        run_frame(0, 0, 0, 0);
        checks++; if (obs_a.size() != 9 || timed_out) begin
            failures++; $display("FAIL abort_restart_reads got=%0d exp=9", obs_a.size()); end
        for (int i = 0; i < exp_t.size(); i++) begin
            checks++; if (i >= obs_t.size() || obs_t[i] !== exp_t[i]) begin
                failures++; $display("FAIL abort_triple[%0d] got=%h exp=%h", i, obs_t[i], exp_t[i]); end
        end
    endtask

    task automatic test_start_handling;
        sel = 0; fill_mem(0); build_model(1);
        run_frame(0, 0, 1, 1);
        checks++; if (obs_a.size() != 9 || timed_out) begin
            failures++; $display("FAIL busy_start_reads got=%0d exp=9", obs_a.size()); end
        for (int i = 0; i < exp_t.size(); i++) begin
            checks++; if (i >= obs_t.size() || obs_t[i] !== exp_t[i]) begin
                failures++; $display("FAIL busy_start_triple[%0d] got=%h exp=%h", i, obs_t[i], exp_t[i]); end
        end
        run_frame(0, 1, 0, 0);
        checks++; if (rise_cyc.size() == 0 || rise_cyc[0] != start_cyc + 5) begin
            failures++; $display("FAIL done_start_latency got=%0d exp=%0d", rise_cyc[0], start_cyc + 5); end
        for (int i = 0; i < exp_t.size(); i++) begin
            checks++; if (i >= obs_t.size() || obs_t[i] !== exp_t[i]) begin
                failures++; $display("FAIL done_start_triple[%0d] got=%h exp=%h", i, obs_t[i], exp_t[i]); end
        end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_backpressure;
        test_two_rows;
        test_random_ready;
        test_reset_abort;
        test_start_handling;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dwt_pair_feeder.md
# dwt_pair_feeder

Streams 8-bit pixels row by row from image memory into the 5/3 lifting wavelet stage, which sits directly downstream. For each output sample pair n of a row it delivers the triple x[2n], x[2n+1], x[2n+2]. At the right edge, x[2n+2] is symmetrically extended. Delivery uses a valid/ready handshake, so the lifting stage never sees a partial pair.

## Interface
- IMG_W, 64: pixels per row; must be even and ≥4.
- IMG_H, 64: rows per frame; must be ≥1.
- AW, 12: memory address width; must satisfy 2^AW ≥ IMG_W*IMG_H.
- clk  in  1  single clock; all state changes on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle frame start request; sampled only in IDLE.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse after the last pair of the frame is accepted.
- mem_rd_en  out  1  read strobe.
- mem_addr  out  AW  read address, row*IMG_W + col.
- mem_rdata  in  8  read data; valid in the cycle after mem_rd_en.
- out_valid  out  1  triple available.
- out_ready  in  1  downstream accepts; a handshake is out_valid & out_ready at a rising edge.
- out_even, out_odd, out_next  out  8 each  x[2n], x[2n+1], x[2n+2] (extended at the right edge).
- out_row_first, out_row_last, out_frame_last  out  1 each  pair flags: n==0, n==IMG_W/2-1, last pair of last row.

## Operation
- FSM states: IDLE, RD_E, RD_O, RD_N, CAP, OUT.
- IDLE: start=1 → RD_E. Row and pair counters clear; row base address clears to 0.
- RD_E issues x[2n], which only happens for n=0 of each row.
- RD_O issues x[2n+1]. It also captures mem_rdata into out_even if the previous state was RD_E.
- RD_N issues x[2n+2], captures odd, then goes to CAP.
- Right-edge extension: on the last pair of a row, RD_N issues address base+IMG_W-2, so out_next = x[IMG_W-2].
- CAP issues nothing, captures next, then goes to OUT.
- OUT: out_valid=1. On handshake:
  - Not the last pair of the row: out_even ← out_next, n+1, go to RD_O (the even sample is not re-read).
  - Last pair, not the last row: base += IMG_W, n=0, go to RD_E.
  - Last pair of the last row: go to IDLE and pulse done in the next cycle.
- mem_rd_en is high in RD_E, RD_O and RD_N only, exactly one read per strobe.
- Per row, exactly IMG_W+1 reads are issued, with no reads outside the frame.
- mem_addr and mem_rd_en are combinational from state, base and n.
- All data and flag outputs are registered. They hold stable while out_valid=1 and out_ready=0.
- Flags are computed from the counters and are valid together with out_valid.
- Address arithmetic is unsigned AW-bit and never wraps for legal parameters.
- start while busy is ignored; it is neither queued nor a restart.

## Timing
- Reset (asynchronous): state IDLE; counters and base cleared. busy, done, mem_rd_en, out_valid, all flags and all data outputs are 0. mem_addr is 0.
- Reset mid-frame aborts immediately: no done pulse and no further reads.
- First triple: start accepted in cycle c → out_valid=1 from cycle c+5.
- Within a row, a handshake at the edge ending cycle t → out_valid low in cycles t+1..t+3 and high again at t+4.
- Across a row boundary, out_valid is low for 4 cycles (RD_E, RD_O, RD_N, CAP).
- done is high in the single cycle after the final handshake; busy is 0 in that cycle.
- A start in the same cycle as done is accepted.
- Backpressure adds no reads and no state change; OUT holds indefinitely.

## Test plan
- IMG_W=8, IMG_H=1, mem[i]=10*i, out_ready=1 → required response:
  - triples (0,10,20), (20,30,40), (40,50,60), (60,70,60);
  - out_row_first on pair 0 only, out_row_last and out_frame_last on pair 3;
  - done one cycle after the last handshake; 9 reads total.
- Latency: first out_valid 5 cycles after start; 3-cycle gaps between pairs within a row; address sequence 0,1,2,3,4,5,6,7,6.
- Backpressure: out_ready=0 for 7 cycles while pair 1 is valid → out_even/out_odd/out_next stay (20,30,40), mem_rd_en stays 0 and busy stays 1; after release the sequence continues unchanged.
- IMG_H=2, IMG_W=8: row 1 starts with reads at addresses 8,9,10 after a 4-cycle gap → out_row_first=1 on that pair. out_frame_last is set only on the final pair, where out_next = mem[14]; row 0's final pair carries out_row_last=1 and out_frame_last=0.
- Reset abort: drive rst_n=0 during RD_N of pair 2 → all outputs 0 immediately and no done. Restarting then reproduces test 1 exactly.
- Start handling: start pulsed while busy has no effect on reads or outputs; start in the done cycle is accepted, with first out_valid 5 cycles later.
